// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm: control FSM sequencing one ASCON-128 encryption on the permutation_xor datapath (optional ASCON_CTRL_CYCLE_CNT_EN adds cycle_count_o)
module ascon_ctrl_fsm #(
    parameter int NB_BLOCKS = 3
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    input  logic                           data_valid_i,
    output logic                           block_ack_o,
    output logic [$clog2(NB_BLOCKS+1)-1:0] block_idx_o,
    output logic [3:0]                     round_o,
    output logic                           input_select_o,
    output logic                           ena_xor_up_o,
    output logic                           ena_xor_down_o,
    output logic [1:0]                     xor_down_sel_o,
    output logic                           ena_reg_state_o,
    output logic                           ena_cipher_o,
    output logic                           ena_tag_o,
    output logic                           busy_o,
    output logic                           done_o
`ifdef ASCON_CTRL_CYCLE_CNT_EN
    ,
    output logic [15:0]                    cycle_count_o
`endif
);
    localparam int IW = $clog2(NB_BLOCKS + 1);

    typedef enum logic [3:0] {IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, WAIT_FIN, FINAL, DONE} state_t;

    state_t          st, st_n;
    logic [3:0]      rnd, rnd_n;
    logic [IW-1:0]   idx, idx_n;
    logic            in_rnd, last, pt_last;

    assign in_rnd  = st inside {INIT, AD, PT, FINAL};
    assign last    = in_rnd && rnd == 4'd11;
    assign pt_last = int'(idx) == NB_BLOCKS - 2;

    // state, round counter and block index registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            st  <= IDLE;
            rnd <= 4'd0;
            idx <= '0;
        end else begin
            st  <= st_n;
            rnd <= rnd_n;
            idx <= idx_n;
        end
    end

    // next state; the round counter reloads whenever a round state is entered
    always_comb begin
        st_n  = st;
        idx_n = idx;
        case (st)
            IDLE:     if (start_i) st_n = INIT;
            INIT:     if (last) st_n = WAIT_AD;
            WAIT_AD:  if (data_valid_i) st_n = AD;
            AD:       if (last) st_n = (NB_BLOCKS > 1) ? WAIT_PT : WAIT_FIN;
            WAIT_PT:  if (data_valid_i) st_n = PT;
            PT: if (last) begin
                idx_n = idx + 1'b1;
                st_n  = (int'(idx) + 1 == NB_BLOCKS - 1) ? WAIT_FIN : WAIT_PT;
            end
            WAIT_FIN: if (data_valid_i) st_n = FINAL;
            FINAL:    if (last) st_n = DONE;
            DONE: begin
                st_n  = IDLE;
                idx_n = '0;
            end
            default:  st_n = IDLE;
        endcase
        rnd_n = (in_rnd && st_n == st) ? rnd + 4'd1 : (st_n == AD || st_n == PT) ? 4'd6 : 4'd0;
    end

    // Moore output decode from registered state, round and block index
    always_comb begin
        block_idx_o     = idx;
        round_o         = in_rnd ? rnd : 4'd0;
        input_select_o  = st == INIT && rnd == 4'd0;
        ena_xor_up_o    = ((st == AD || st == PT) && rnd == 4'd6) || (st == FINAL && rnd == 4'd0);
        block_ack_o     = ena_xor_up_o;
        ena_cipher_o    = (st == PT && rnd == 4'd6) || (st == FINAL && rnd == 4'd0);
        ena_xor_down_o  = last && (st != PT || pt_last);
        xor_down_sel_o  = (st == AD && last) ? ((NB_BLOCKS == 1) ? 2'd3 : 2'd1) :
                          (st == PT && last && pt_last) ? 2'd2 : 2'd0;
        ena_tag_o       = st == FINAL && last;
        ena_reg_state_o = in_rnd;
        busy_o          = st != IDLE && st != DONE;
        done_o          = st == DONE;
    end

`ifdef ASCON_CTRL_CYCLE_CNT_EN
    // saturating busy-cycle counter, cleared when a start is accepted
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            cycle_count_o <= 16'd0;
        else if (st == IDLE && start_i)
            cycle_count_o <= 16'd0;
        else if (busy_o && cycle_count_o != 16'hFFFF)
            cycle_count_o <= cycle_count_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb_ascon_ctrl_fsm: trace-model bench for ascon_ctrl_fsm with NB_BLOCKS = 3 and 1
module tb_ascon_ctrl_fsm;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0, use1 = 1'b0;
    logic start3, start1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign start3 = start & ~use1;
    assign start1 = start & use1;

    logic a3, i3s, u3, d3, r3, c3, t3, b3, n3;
    logic [1:0] x3, s3;
    logic [3:0] rd3;
    logic a1, i1s, u1, d1, r1, c1, t1, b1, n1;
    logic [0:0] x1;
    logic [1:0] s1;
    logic [3:0] rd1;
`ifdef ASCON_CTRL_CYCLE_CNT_EN
    logic [15:0] cc3, cc1;
`endif

    ascon_ctrl_fsm #(.NB_BLOCKS(3)) dut3 (
        .clock_i(clk), .reset_i(rst), .start_i(start3), .data_valid_i(valid),
        .block_ack_o(a3), .block_idx_o(x3), .round_o(rd3), .input_select_o(i3s),
        .ena_xor_up_o(u3), .ena_xor_down_o(d3), .xor_down_sel_o(s3), .ena_reg_state_o(r3),
        .ena_cipher_o(c3), .ena_tag_o(t3), .busy_o(b3), .done_o(n3)
`ifdef ASCON_CTRL_CYCLE_CNT_EN
        , .cycle_count_o(cc3)
`endif
    );

    ascon_ctrl_fsm #(.NB_BLOCKS(1)) dut1 (
        .clock_i(clk), .reset_i(rst), .start_i(start1), .data_valid_i(valid),
        .block_ack_o(a1), .block_idx_o(x1), .round_o(rd1), .input_select_o(i1s),
        .ena_xor_up_o(u1), .ena_xor_down_o(d1), .xor_down_sel_o(s1), .ena_reg_state_o(r1),
        .ena_cipher_o(c1), .ena_tag_o(t1), .busy_o(b1), .done_o(n1)
`ifdef ASCON_CTRL_CYCLE_CNT_EN
        , .cycle_count_o(cc1)
`endif
    );

    // packed view: {ack, idx[1:0], round[3:0], isel, up, down, sel[1:0], reg, cipher, tag, busy, done}
    logic [16:0] vec;
    always_comb vec = use1 ? {a1, 1'b0, x1, rd1, i1s, u1, d1, s1, r1, c1, t1, b1, n1}
                           : {a3, x3, rd3, i3s, u3, d3, s3, r3, c3, t3, b3, n3};

    typedef struct {
        logic [16:0] o;
        bit          s;
        bit          v;
    } ent_t;
    ent_t q[$];

    function automatic logic [16:0] mk(int r, bit rs, bit isel, bit up, bit ci, bit dn, int sel,
                                       bit tg, bit busy, bit done, int idx);
        return {up, 2'(idx), 4'(r), isel, up, dn, 2'(sel), rs, ci, tg, busy, done};
    endfunction

    task automatic chk(string name, logic [16:0] act, logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected cycle-by-cycle trace of one encryption, followed by DONE and one IDLE cycle
    task automatic build(int nb, int stall, bit sb);
        q.delete();
        for (int r = 0; r < 12; r++)
            q.push_back('{mk(r, 1, r == 0, 0, 0, r == 11, 0, 0, 1, 0, 0), 1'b0, 1'b1});
        q.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, 1'b1});
        for (int r = 6; r < 12; r++)
            q.push_back('{mk(r, 1, 0, r == 6, 0, r == 11, (r == 11) ? ((nb == 1) ? 3 : 1) : 0,
                             0, 1, 0, 0), sb && r == 8, 1'b1});
        for (int b = 0; b < nb - 1; b++) begin
            if (b == 0)
                for (int i = 0; i < stall; i++)
                    q.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b), 1'b0, 1'b0});
            q.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b), 1'b0, 1'b1});
            for (int r = 6; r < 12; r++)
                q.push_back('{mk(r, 1, 0, r == 6, r == 6, r == 11 && b == nb - 2,
                                 (r == 11 && b == nb - 2) ? 2 : 0, 0, 1, 0, b), 1'b0, 1'b1});
        end
        q.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, nb - 1), 1'b0, 1'b1});
        for (int r = 0; r < 12; r++)
            q.push_back('{mk(r, 1, 0, r == 0, r == 0, r == 11, 0, r == 11, 1, 0, nb - 1), 1'b0, 1'b1});
        q.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, nb - 1), 1'b0, 1'b1});
        q.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1});
    endtask

    function automatic int count_bit(int pos);
        int n = 0;
        foreach (q[k]) n += int'(q[k].o[pos]);
        return n;
    endfunction

    function automatic int first_bit(int pos);
        foreach (q[k]) if (q[k].o[pos]) return k;
        return -1;
    endfunction

    function automatic int sel_seq();
        int s = 0;
        foreach (q[k]) if (q[k].o[7]) s = (s << 2) | int'(q[k].o[6:5]);
        return s;
    endfunction

    // start the active DUT and compare every cycle of the trace, optionally stopping after cycle abort
    task automatic run(string tag, int abort);
        int busy_n = 0;
        @(negedge clk);
        start = 1'b1;
        valid = 1'b1;
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            chk($sformatf("%s_cyc%0d", tag, k), vec, q[k].o);
            busy_n += int'(q[k].o[1]);
`ifdef ASCON_CTRL_CYCLE_CNT_EN
            if (q[k].o[0]) chk_i({tag, "_cycle_count"}, int'(use1 ? cc1 : cc3), busy_n);
`endif
            start = q[k].s;
            valid = q[k].v;
            if (k == abort) return;
        end
    endtask

    initial begin
        start = 1'b1;
        valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", vec, 17'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_init_r0", vec, mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        build(3, 0, 0);
        chk_i("model_len_nb3", q.size(), 48);
        chk_i("model_busy_nb3", count_bit(1), 46);
        chk_i("model_ack_nb3", count_bit(16), 4);
        chk_i("model_cipher_nb3", count_bit(3), 3);
        chk_i("model_tag_pos", first_bit(2), 45);
        chk_i("model_done_pos", first_bit(0), 46);
        chk_i("model_sel_seq_nb3", sel_seq(), 'b00_01_10_00);
        run("full3", -1);

        build(3, 0, 1);
        run("start_busy", -1);

        build(3, 5, 0);
        chk_i("model_busy_stall", count_bit(1), 51);
        run("stall", -1);

        build(3, 0, 0);
        run("pre_reset", 22);
        rst = 1'b1;
        #1;
        chk("mid_reset_outputs", vec, 17'h0);
`ifdef ASCON_CTRL_CYCLE_CNT_EN
        chk_i("mid_reset_count", int'(cc3), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        run("replay", -1);

        use1 = 1'b1;
        build(1, 0, 0);
        chk_i("model_busy_nb1", count_bit(1), 32);
        chk_i("model_sel_seq_nb1", sel_seq(), 'b11_00);
        run("full1", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
